// File: rtl/vga_cell_scanner.sv
// vga_cell_scanner: 640x480@60 raster timing that scans a 40x30 cell buffer of colour IDs
// and arbitrates its single port between display reads (priority) and CPU writes.
module vga_cell_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELLS_X  = 40,
  parameter int CELLS_Y  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [10:0] wr_addr_i,
  input  logic [3:0]  wr_data_i,
  output logic [3:0]  color_id_o,
  output logic        de_o,
  output logic        hsync_n_o,
  output logic        vsync_n_o,
  output logic        vblank_o,
  output logic        frame_start_o
);
  localparam int CELLS = CELLS_X * CELLS_Y;
  localparam int AW = $clog2(CELLS);
  localparam logic [10:0] NCELLS = 11'(CELLS);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [3:0]  mem [CELLS];
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [3:0]  color_q, color_d;
  logic        de_q, de_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d, vb_q, vb_d, fs_q, fs_d;
  logic        active, last_h;
  logic [5:0]  row;
  logic [10:0] rd_addr;

  // Row*40 as (r<<5)+(r<<3) keeps the address path free of a multiplier.
  always_comb begin
    active     = (h_q < HA) && (v_q < VA);
    last_h     = h_q == HL;
    row        = v_q[9:4];
    rd_addr    = {row, 5'b0} + {2'b0, row, 3'b0} + {5'b0, h_q[9:4]};
    wr_ready_o = !(pix_en_i && active);
    h_d        = !pix_en_i ? h_q : last_h ? 10'd0 : h_q + 10'd1;
    v_d        = !(pix_en_i && last_h) ? v_q : v_q == VL ? 10'd0 : v_q + 10'd1;
    color_d    = !pix_en_i ? color_q : active ? mem[rd_addr[AW-1:0]] : 4'hF;
    de_d       = pix_en_i ? active : de_q;
    hs_n_d     = pix_en_i ? !(h_q >= HS0 && h_q < HS1) : hs_n_q;
    vs_n_d     = pix_en_i ? !(v_q >= VS0 && v_q < VS1) : vs_n_q;
    vb_d       = pix_en_i ? v_q >= VA : vb_q;
    fs_d       = pix_en_i && last_h && v_q == VL;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      color_q <= 4'hF;
      de_q    <= 1'b0;
      hs_n_q  <= 1'b1;
      vs_n_q  <= 1'b1;
      vb_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      color_q <= color_d;
      de_q    <= de_d;
      hs_n_q  <= hs_n_d;
      vs_n_q  <= vs_n_d;
      vb_q    <= vb_d;
      fs_q    <= fs_d;
    end

  // Out-of-range addresses still complete the handshake; the data is simply dropped.
  always_ff @(posedge clk)
    if (wr_valid_i && wr_ready_o && wr_addr_i < NCELLS) mem[wr_addr_i[AW-1:0]] <= wr_data_i;

  assign color_id_o    = color_q;
  assign de_o          = de_q;
  assign hsync_n_o     = hs_n_q;
  assign vsync_n_o     = vs_n_q;
  assign vblank_o      = vb_q;
  assign frame_start_o = fs_q;
endmodule
